// File: rtl/fir_ctrl.sv
// fir_ctrl: sequential FIR engine, one multiply-accumulate per cycle, N+2 cycles per output.
// Build option FIR_SAT_EN: saturate each result to 16 bits instead of wrapping.
module fir_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 38
) (
    input  logic              clk_b,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [5:0]        Ile_wsp,
    input  logic [13:0]       Ile_probek,
    output logic [4:0]        address_FIR,
    input  logic [DATA_W-1:0] wsp_data,
    output logic              FSM_MUX_CDC,
    output logic [13:0]       probka_adres,
    input  logic [DATA_W-1:0] probka_data,
    output logic [13:0]       wynik_adres,
    output logic [DATA_W-1:0] wynik_data,
    output logic              wynik_wr,
    output logic              pracuje,
    output logic              DONE
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;
    localparam int         FRAC  = DATA_W - 1;

    logic [2:0]               state_q, state_d;
    logic                     start_prev_q;
    logic [4:0]               k_q, k_d, k_last_q, k_last_d;
    logic [13:0]              n_q, n_d, n_last_q, n_last_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     term_vld_q, term_vld_d;

    logic                      start_rise;
    logic                      term_in_range;
    logic [5:0]                wsp_clamp;
    logic signed [2*DATA_W-1:0] coef_ext, samp_ext, prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [DATA_W-1:0]         result;

    assign start_rise    = Start & ~start_prev_q;
    assign wsp_clamp     = (Ile_wsp > 6'd32) ? 6'd32 : Ile_wsp;
    assign term_in_range = (n_q >= {9'd0, k_q});
    assign coef_ext      = {{DATA_W{wsp_data[DATA_W-1]}}, wsp_data};
    assign samp_ext      = {{DATA_W{probka_data[DATA_W-1]}}, probka_data};
    assign prod          = coef_ext * samp_ext;
    assign prod_ext      = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

`ifdef FIR_SAT_EN
    // acc>>>FRAC fits in DATA_W bits only when every bit from 2*DATA_W-2 upward agrees
    logic [ACC_W-2*DATA_W+1:0] acc_top;
    assign acc_top = acc_q[ACC_W-1:2*DATA_W-2];
    always_comb begin
        if ((&acc_top) || !(|acc_top)) result = acc_q[2*DATA_W-2:FRAC];
        else if (acc_top[ACC_W-2*DATA_W+1]) result = {1'b1, {(DATA_W-1){1'b0}}};
        else result = {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    assign result = acc_q[2*DATA_W-2:FRAC];
`endif

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        k_last_d   = k_last_q;
        n_last_d   = n_last_q;
        term_vld_d = 1'b0;
        acc_d      = term_vld_q ? (acc_q + prod_ext) : acc_q;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    k_last_d = 5'(wsp_clamp - 6'd1);
                    n_last_d = Ile_probek - 14'd1;
                    k_d      = 5'd0;
                    n_d      = 14'd0;
                    acc_d    = '0;
                    state_d  = (wsp_clamp == 6'd0 || Ile_probek == 14'd0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                // Out-of-range history terms still take a slot but contribute zero
                term_vld_d = term_in_range;
                if (k_q == k_last_q) state_d = DRAIN;
                else k_d = k_q + 5'd1;
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                if (n_q != n_last_q) begin
                    n_d     = n_q + 14'd1;
                    k_d     = 5'd0;
                    acc_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and all reset asynchronously.
    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            start_prev_q <= 1'b1;
            k_q          <= 5'd0;
            k_last_q     <= 5'd0;
            n_q          <= 14'd0;
            n_last_q     <= 14'd0;
            acc_q        <= '0;
            term_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= Start;
            k_q          <= k_d;
            k_last_q     <= k_last_d;
            n_q          <= n_d;
            n_last_q     <= n_last_d;
            acc_q        <= acc_d;
            term_vld_q   <= term_vld_d;
        end
    end

    assign pracuje      = (state_q != IDLE);
    assign FSM_MUX_CDC  = (state_q == IDLE);
    assign DONE         = (state_q == FIN);
    assign wynik_wr     = (state_q == WRITE);
    assign address_FIR  = (state_q == FETCH) ? k_q : 5'd0;
    assign probka_adres = (state_q == FETCH && term_in_range) ? (n_q - {9'd0, k_q}) : 14'd0;
    assign wynik_adres  = wynik_wr ? n_q : 14'd0;
    assign wynik_data   = wynik_wr ? result : '0;

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl: spec vectors plus randomized runs against a direct convolution model.
module tb_fir_ctrl;
    logic        clk_b = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [5:0]  Ile_wsp;
    logic [13:0] Ile_probek;
    logic [4:0]  address_FIR;
    logic [15:0] wsp_data;
    logic        FSM_MUX_CDC;
    logic [13:0] probka_adres;
    logic [15:0] probka_data;
    logic [13:0] wynik_adres;
    logic [15:0] wynik_data;
    logic        wynik_wr;
    logic        pracuje;
    logic        DONE;

    logic [15:0] coef [32];
    logic [15:0] samp [16384];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int mux_bad = 0;
    int res_addr [$];
    logic [15:0] res_data [$];
    int res_cyc [$];

    fir_ctrl #(.DATA_W(16), .ACC_W(38)) dut (
        .clk_b(clk_b), .rst_n(rst_n), .Start(Start), .Ile_wsp(Ile_wsp),
        .Ile_probek(Ile_probek), .address_FIR(address_FIR), .wsp_data(wsp_data),
        .FSM_MUX_CDC(FSM_MUX_CDC), .probka_adres(probka_adres), .probka_data(probka_data),
        .wynik_adres(wynik_adres), .wynik_data(wynik_data), .wynik_wr(wynik_wr),
        .pracuje(pracuje), .DONE(DONE)
    );

    always #5 clk_b = ~clk_b;

    // Memories with one cycle of read latency; bus side of the coefficient mux parks at 0
    always @(posedge clk_b) begin
        wsp_data    <= coef[FSM_MUX_CDC ? 5'd0 : address_FIR];
        probka_data <= samp[probka_adres];
        cyc         <= cyc + 1;
    end

    always @(negedge clk_b) begin
        if (wynik_wr === 1'b1) begin
            res_addr.push_back(int'(wynik_adres));
            res_data.push_back(wynik_data);
            res_cyc.push_back(cyc);
        end
        if (DONE === 1'b1) done_cnt++;
        if (pracuje === 1'b1) busy_cnt++;
        if (FSM_MUX_CDC !== ~pracuje) mux_bad++;
    end

    function automatic logic [15:0] ref_y(input int n, input int nn);
        longint acc = 0;
        longint sh;
        for (int k = 0; k < nn; k++)
            if (n - k >= 0) acc += longint'($signed(coef[k])) * longint'($signed(samp[n-k]));
        sh = acc >>> 15;
`ifdef FIR_SAT_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
`endif
        return sh[15:0];
    endfunction

    task automatic launch(input int nw, input int m);
        Start = 1'b0;
        Ile_wsp = 6'(nw);
        Ile_probek = 14'(m);
        @(posedge clk_b); #1;
        res_addr.delete(); res_data.delete(); res_cyc.delete();
        done_cnt = 0; busy_cnt = 0;
        Start = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk_b); #1;
            i++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s: DONE not seen within %0d cycles", name, budget);
        end
        repeat (3) @(negedge clk_b);
        #1;
    endtask

    task automatic check_results(input string name, input int n_eff, input int m);
        int n_got = res_data.size();
        int bad_gap = 0;
        checks++;
        if (n_got != m) begin
            errors++;
            $display("FAIL %s count: got %0d results, want %0d", name, n_got, m);
        end
        for (int i = 0; i < n_got && i < m; i++) begin
            checks++;
            if (res_addr[i] != i) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %0d want %0d", name, i, res_addr[i], i);
            end
            checks++;
            if (res_data[i] !== ref_y(i, n_eff)) begin
                errors++;
                $display("FAIL %s y[%0d]: got %h want %h", name, i, res_data[i], ref_y(i, n_eff));
            end
        end
        if (n_got > 0) begin
            checks++;
            if (res_cyc[0] - start_cyc != n_eff + 2) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, res_cyc[0] - start_cyc, n_eff + 2);
            end
            for (int i = 1; i < n_got; i++)
                if (res_cyc[i] - res_cyc[i-1] != n_eff + 2) bad_gap++;
            checks++;
            if (bad_gap != 0) begin
                errors++;
                $display("FAIL %s throughput: %0d gaps differ from %0d", name, bad_gap, n_eff + 2);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [63:0] got;
        logic [63:0] want;
        got  = {pracuje, DONE, wynik_wr, FSM_MUX_CDC, address_FIR, probka_adres, wynik_adres, wynik_data};
        want = {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 14'd0, 14'd0, 16'd0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s outputs: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Start = 1'b1;
        Ile_wsp = 6'd4;
        Ile_probek = 14'd4;
        repeat (3) @(negedge clk_b);
        #1;
        check_idle_outputs("reset");
        @(posedge clk_b); #1;
        rst_n = 1'b1;
        busy_cnt = 0;
        repeat (8) @(negedge clk_b);
        #1;
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL reset_start_high: busy for %0d cycles, want 0", busy_cnt);
        end
        check_idle_outputs("after_release");
        Start = 1'b0;
        @(negedge clk_b);
    endtask

    task automatic test_single_tap();
        logic [15:0] exp_y [3];
        exp_y = '{16'h1000, 16'h0800, 16'hF000};
        coef[0] = 16'h4000;
        samp[0] = 16'h2000; samp[1] = 16'h1000; samp[2] = 16'hE000;
        launch(1, 3);
        wait_done("single_tap", 40);
        check_results("single_tap", 1, 3);
        for (int i = 0; i < 3 && i < res_data.size(); i++) begin
            checks++;
            if (res_data[i] !== exp_y[i]) begin
                errors++;
                $display("FAIL single_tap_const y[%0d]: got %h want %h", i, res_data[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_impulse();
        logic [15:0] exp_y [5];
        exp_y = '{16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h0000, 16'h0000};
        for (int i = 0; i < 3; i++) coef[i] = 16'h7FFF;
        samp[0] = 16'h7FFF;
        for (int i = 1; i < 5; i++) samp[i] = 16'h0000;
        launch(3, 5);
        wait_done("impulse", 60);
        check_results("impulse", 3, 5);
        for (int i = 0; i < 5 && i < res_data.size(); i++) begin
            checks++;
            if (res_data[i] !== exp_y[i]) begin
                errors++;
                $display("FAIL impulse_const y[%0d]: got %h want %h", i, res_data[i], exp_y[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_y1;
`ifdef FIR_SAT_EN
        exp_y1 = 16'h7FFF;
`else
        exp_y1 = 16'hFFFC;
`endif
        coef[0] = 16'h7FFF; coef[1] = 16'h7FFF;
        samp[0] = 16'h7FFF; samp[1] = 16'h7FFF;
        launch(2, 2);
        wait_done("overflow", 40);
        check_results("overflow", 2, 2);
        checks++;
        if (res_data.size() < 2 || res_data[1] !== exp_y1) begin
            errors++;
            $display("FAIL overflow_const y[1]: got %h want %h",
                     (res_data.size() < 2) ? 16'hxxxx : res_data[1], exp_y1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(1, 40);
            int m = $urandom_range(1, 6);
            int n_eff = (nw > 32) ? 32 : nw;
            for (int i = 0; i < 32; i++) coef[i] = 16'($urandom);
            for (int i = 0; i < m; i++) samp[i] = (r == 0) ? 16'h8000 : 16'($urandom);
            if (r == 0) for (int i = 0; i < 32; i++) coef[i] = 16'h8000;
            launch(nw, m);
            @(posedge clk_b); #1;
            // Length inputs change mid-run; the captured values must govern
            Ile_wsp = 6'($urandom);
            Ile_probek = 14'($urandom);
            Start = 1'b0;
            wait_done("random", (n_eff + 2) * m + 20);
            check_results("random", n_eff, m);
        end
    endtask

    task automatic test_zero_length();
        launch(5, 0);
        wait_done("zero_m", 20);
        checks++;
        if (busy_cnt != 1 || done_cnt != 1 || res_data.size() != 0) begin
            errors++;
            $display("FAIL zero_m: busy %0d done %0d writes %0d, want 1 1 0",
                     busy_cnt, done_cnt, res_data.size());
        end
        launch(0, 4);
        wait_done("zero_n", 20);
        checks++;
        if (busy_cnt != 1 || done_cnt != 1 || res_data.size() != 0) begin
            errors++;
            $display("FAIL zero_n: busy %0d done %0d writes %0d, want 1 1 0",
                     busy_cnt, done_cnt, res_data.size());
        end
        Start = 1'b0;
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 3; i++) coef[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) samp[i] = 16'($urandom);
        mux_bad = 0;
        launch(3, 4);
        repeat (3) @(posedge clk_b);
        #1 Start = 1'b0;
        repeat (2) @(posedge clk_b);
        #1 Start = 1'b1;
        wait_done("start_ignored", 60);
        repeat (20) @(negedge clk_b);
        #1;
        check_results("start_ignored", 3, 4);
        checks++;
        if (pracuje !== 1'b0 || mux_bad != 0) begin
            errors++;
            $display("FAIL start_ignored idle: pracuje %b mux_bad %0d, want 0 0", pracuje, mux_bad);
        end
        Start = 1'b0;
        @(negedge clk_b);
    endtask

    task automatic test_reset_midrun();
        int i = 0;
        for (int j = 0; j < 4; j++) coef[j] = 16'($urandom);
        for (int j = 0; j < 4; j++) samp[j] = 16'($urandom);
        launch(4, 4);
        while (res_data.size() < 2 && i < 40) begin
            @(negedge clk_b); #1;
            i++;
        end
        checks++;
        if (res_data.size() < 2) begin
            errors++;
            $display("FAIL reset_midrun: only %0d results before abort point, want 2", res_data.size());
        end
        @(negedge clk_b);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset_midrun");
        repeat (2) @(negedge clk_b);
        @(posedge clk_b); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk_b);
        #1;
        checks++;
        if (done_cnt != 0 || pracuje !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun abort: done %0d pracuje %b, want 0 0", done_cnt, pracuje);
        end
        launch(4, 4);
        wait_done("rerun", 60);
        check_results("rerun", 4, 4);
        Start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) coef[i] = 16'h0000;
        for (int i = 0; i < 64; i++) samp[i] = 16'h0000;
        test_reset();
        test_single_tap();
        test_impulse();
        test_overflow();
        test_random();
        test_zero_length();
        test_start_ignored();
        test_reset_midrun();
        checks++;
        if (mux_bad != 0) begin
            errors++;
            $display("FAIL mux_select: %0d cycles with FSM_MUX_CDC != !pracuje", mux_bad);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter DATA_W, 16, width of coefficients, samples and results (signed Q15).
REQ-002 Parameter ACC_W, 38, accumulator width (2*DATA_W + 6 guard bits).
REQ-003 clk_b  in  1  block clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 Start  in  1  run request from the control registers.
REQ-006 Ile_wsp  in  6  number of coefficients N; valid values 1..32.
REQ-007 Ile_probek  in  14  number of input samples M to filter.
REQ-008 address_FIR  out  5  coefficient RAM read address.
REQ-009 wsp_data  in  16  coefficient RAM read data; 1-cycle read latency.
REQ-010 FSM_MUX_CDC  out  1  coefficient RAM address select; 1 = bus-side address, 0 = address_FIR.
REQ-011 probka_adres  out  14  sample memory read address.
REQ-012 probka_data  in  16  sample memory read data; 1-cycle read latency.
REQ-013 wynik_adres  out  14  result memory write address.
REQ-014 wynik_data  out  16  result sample.
REQ-015 wynik_wr  out  1  result write strobe, one cycle per result.
REQ-016 pracuje  out  1  busy; high in every state except IDLE.
REQ-017 DONE  out  1  one-cycle pulse at the end of a run.

Function
REQ-018 The block SHALL compute y[n] = sum over k=0..N-1 of h[k]*x[n-k] for n=0..M-1, with x[j]=0 for j<0.
REQ-019 States SHALL be IDLE, FETCH, DRAIN, WRITE and FIN.
REQ-020 IDLE->FETCH SHALL occur on the first cycle Start is high after having been low (rising edge); n=0, k=0, accumulator cleared.
REQ-021 In FETCH the block SHALL drive address_FIR=k and probka_adres=n-k, incrementing k each cycle; after k=N-1 it SHALL go to DRAIN.
REQ-022 The product of the data returned one cycle after each FETCH address SHALL be accumulated; terms with n-k<0 SHALL add zero, with probka_adres driven to 0.
REQ-023 Products SHALL be signed 16x16 to 32 bits, sign-extended to ACC_W; accumulation SHALL never wrap for N<=32.
REQ-024 DRAIN SHALL last one cycle (final product); WRITE SHALL last one cycle with wynik_wr=1, wynik_adres=n, wynik_data=acc>>>15 (arithmetic) reduced to 16 bits per REQ-036.
REQ-025 After WRITE: if n<M-1, n increments, acc clears, k=0, next state FETCH; else next state FIN.
REQ-026 FIN SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-027 Throughput SHALL be N+2 cycles per output sample; first wynik_wr at cycle N+2 after the Start edge cycle.
REQ-028 Ile_wsp and Ile_probek SHALL be captured on the Start edge; later changes SHALL have no effect on the current run.
REQ-029 Ile_wsp>32 SHALL be treated as 32.
REQ-030 Ile_wsp=0 or Ile_probek=0 SHALL go from IDLE directly to FIN: DONE pulses, no wynik_wr.
REQ-031 Start while not in IDLE SHALL be ignored; Start held high through FIN SHALL NOT start a new run.
REQ-032 FSM_MUX_CDC SHALL be 1 in IDLE and 0 in all other states.

Reset
REQ-033 While rst_n=0: state=IDLE; pracuje, DONE and wynik_wr=0; address_FIR, probka_adres, wynik_adres and wynik_data=0; FSM_MUX_CDC=1; accumulator, counters and the Start edge detector cleared.
REQ-034 Reset asserted mid-run SHALL abort the run with no DONE pulse; after release, the block SHALL wait for a new Start rising edge.
REQ-035 The Start edge detector SHALL reset to "previous Start = 1", so a Start already high at reset release does not launch a run.

Configuration
REQ-036 Macro FIR_SAT_EN defined: acc>>>15 SHALL be saturated to 0x7FFF..0x8000; undefined: its low 16 bits SHALL be output (wrap).

Verification
REQ-037 N=1, h[0]=0x4000, M=3, x=0x2000,0x1000,0xE000 -> wynik_data 0x1000,0x0800,0xF000 at addresses 0,1,2; 3 wynik_wr pulses, then 1 DONE.
REQ-038 N=3, h=0x7FFF x3, M=5, x=0x7FFF,0,0,0,0 -> y=0x7FFE,0x7FFE,0x7FFE,0,0; first wynik_wr 5 cycles after Start edge.
REQ-039 N=2, h=0x7FFF,0x7FFF, M=2, x=0x7FFF,0x7FFF -> y[1]=0x7FFF with FIR_SAT_EN, 0xFFFC without.
REQ-040 Start pulsed mid-run and held high past DONE -> exactly one run, one DONE; FSM_MUX_CDC=0 only while pracuje=1.
REQ-041 Ile_probek=0, Start edge -> pracuje high 1 cycle (FIN), DONE pulse, no wynik_wr.
REQ-042 rst_n low during FETCH of sample 2 -> all outputs at reset values, no DONE; new Start runs M samples from n=0.
